// File: rtl/riscv_victim_cache_assoc_pkg.sv
// Shared definitions for the victim cache: default geometry, insert-path
// classification and the eviction message layout used toward memory.
package riscv_victim_cache_assoc_pkg;

    localparam int VC_ENTRIES = 4;
    localparam int VC_WAY_W   = $clog2(VC_ENTRIES);
    localparam int VC_TAG_W   = 20;
    localparam int VC_IDX_W   = 6;
    localparam int VC_BLK_W   = 32;

    typedef enum logic [2:0] {
        INS_NONE,
        INS_SWAP,
        INS_MERGE,
        INS_FILL,
        INS_REPLACE
    } ins_kind_e;

    // Field order tag|idx|data, shared with the memory-side arbiter.
    typedef struct packed {
        logic [VC_TAG_W-1:0] tag;
        logic [VC_IDX_W-1:0] idx;
        logic [VC_BLK_W-1:0] data;
    } evict_msg_t;

    function automatic evict_msg_t pack_evict(logic [VC_TAG_W-1:0] tag,
                                              logic [VC_IDX_W-1:0] idx,
                                              logic [VC_BLK_W-1:0] data);
        evict_msg_t m;
        m.tag  = tag;
        m.idx  = idx;
        m.data = data;
        return m;
    endfunction

endpackage

// File: rtl/riscv_victim_cache_assoc_if.sv
// Probe/extract, insert and write-back eviction signals of the victim cache.
// The L1/memory side uses master; the cache itself uses slave.
interface riscv_victim_cache_assoc_if
    import riscv_victim_cache_assoc_pkg::*;
#(
    parameter int WAY_W = VC_WAY_W,
    parameter int TAG_W = VC_TAG_W,
    parameter int IDX_W = VC_IDX_W,
    parameter int BLK_W = VC_BLK_W
);
    logic             lookup_en;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_hit;
    logic [WAY_W-1:0] lookup_way;
    logic [BLK_W-1:0] lookup_data;
    logic             lookup_dirty;
    logic             extract_en;
    logic             insert_en;
    logic [TAG_W-1:0] insert_tag;
    logic [IDX_W-1:0] insert_idx;
    logic [BLK_W-1:0] insert_data;
    logic             insert_dirty;
    logic             insert_rdy;
    logic             evict_val;
    logic             evict_rdy;
    logic [TAG_W-1:0] evict_tag;
    logic [IDX_W-1:0] evict_idx;
    logic [BLK_W-1:0] evict_data;
    logic [WAY_W:0]   occupancy;

    modport master (
        output lookup_en, lookup_tag, lookup_idx, extract_en,
               insert_en, insert_tag, insert_idx, insert_data, insert_dirty,
               evict_rdy,
        input  lookup_hit, lookup_way, lookup_data, lookup_dirty, insert_rdy,
               evict_val, evict_tag, evict_idx, evict_data, occupancy
    );

    modport slave (
        input  lookup_en, lookup_tag, lookup_idx, extract_en,
               insert_en, insert_tag, insert_idx, insert_data, insert_dirty,
               evict_rdy,
        output lookup_hit, lookup_way, lookup_data, lookup_dirty, insert_rdy,
               evict_val, evict_tag, evict_idx, evict_data, occupancy
    );

endinterface

// File: rtl/riscv_victim_cache_assoc_lru.sv
// True-LRU age tracker: ages are a permutation of 0..ENTRIES-1, 0 = MRU.
// Touch makes a way MRU; invalidate sends it to the LRU position.
module riscv_lru_age_tracker #(
    parameter int ENTRIES = 4,
    parameter int WAY_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             touch_en,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             inval_en,
    input  logic [WAY_W-1:0] inval_way,
    output logic [WAY_W-1:0] ages [ENTRIES]
);

    logic [WAY_W-1:0] age_q [ENTRIES];
    logic [WAY_W-1:0] age_d [ENTRIES];
    logic [WAY_W-1:0] ref_age;

    always_comb begin
        age_d   = age_q;
        ref_age = '0;
        if (touch_en) begin
            ref_age = age_q[touch_way];
            for (int i = 0; i < ENTRIES; i++) begin
                if (WAY_W'(i) == touch_way)
                    age_d[i] = '0;
                else if (age_q[i] < ref_age)
                    age_d[i] = age_q[i] + 1'b1;
            end
        end else if (inval_en) begin
            ref_age = age_q[inval_way];
            for (int i = 0; i < ENTRIES; i++) begin
                if (WAY_W'(i) == inval_way)
                    age_d[i] = WAY_W'(ENTRIES - 1);
                else if (age_q[i] > ref_age)
                    age_d[i] = age_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                age_q[i] <= WAY_W'(i);
        end else begin
            age_q <= age_d;
        end
    end

    assign ages = age_q;

endmodule

// File: rtl/riscv_victim_cache_assoc.sv
// Fully-associative victim cache beside L1: stores L1 victims, serves L1-miss
// probes with swap-back, and writes displaced dirty blocks out via evict_*.
module riscv_victim_cache_assoc
    import riscv_victim_cache_assoc_pkg::*;
#(
    parameter int ENTRIES = VC_ENTRIES,
    parameter int WAY_W   = VC_WAY_W,
    parameter int TAG_W   = VC_TAG_W,
    parameter int IDX_W   = VC_IDX_W,
    parameter int BLK_W   = VC_BLK_W
) (
    input  logic                      clk,
    input  logic                      reset,
    riscv_victim_cache_assoc_if.slave bus
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_d  [ENTRIES];
    logic [IDX_W-1:0]   idx_q  [ENTRIES];
    logic [IDX_W-1:0]   idx_d  [ENTRIES];
    logic [BLK_W-1:0]   data_q [ENTRIES];
    logic [BLK_W-1:0]   data_d [ENTRIES];
    logic [WAY_W:0]     occ_q, occ_d;
    logic               evict_val_q, evict_val_d;
    logic [TAG_W-1:0]   evict_tag_q, evict_tag_d;
    logic [IDX_W-1:0]   evict_idx_q, evict_idx_d;
    logic [BLK_W-1:0]   evict_data_q, evict_data_d;

    logic [ENTRIES-1:0] hit_vec, ins_vec;
    logic [WAY_W-1:0]   hit_way, merge_way, free_way, lru_way, tgt_way;
    logic [WAY_W-1:0]   ages [ENTRIES];
    logic               hit_any, probe_hit, do_extract, insert_rdy, ins_acc, new_evict;
    logic               touch_en, inval_en;
    logic [WAY_W-1:0]   touch_way;
    ins_kind_e          ins_kind;

    riscv_lru_age_tracker #(
        .ENTRIES (ENTRIES),
        .WAY_W   (WAY_W)
    ) u_lru (
        .clk       (clk),
        .reset     (reset),
        .touch_en  (touch_en),
        .touch_way (touch_way),
        .inval_en  (inval_en),
        .inval_way (hit_way),
        .ages      (ages)
    );

    always_comb begin
        hit_vec = '0;
        ins_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_vec[i] = valid_q[i] && (tag_q[i] == bus.lookup_tag) && (idx_q[i] == bus.lookup_idx);
            ins_vec[i] = valid_q[i] && (tag_q[i] == bus.insert_tag) && (idx_q[i] == bus.insert_idx);
        end
    end

    // Descending scan so the lowest matching index wins each priority encoder.
    always_comb begin
        hit_way   = '0;
        merge_way = '0;
        free_way  = '0;
        lru_way   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i])                        hit_way   = WAY_W'(i);
            if (ins_vec[i])                        merge_way = WAY_W'(i);
            if (!valid_q[i])                       free_way  = WAY_W'(i);
            if (ages[i] == WAY_W'(ENTRIES - 1))    lru_way   = WAY_W'(i);
        end
    end

    assign hit_any    = |hit_vec;
    assign probe_hit  = bus.lookup_en && hit_any;
    assign do_extract = probe_hit && bus.extract_en;
    assign insert_rdy = !evict_val_q || bus.evict_rdy;
    assign ins_acc    = bus.insert_en && insert_rdy;

    always_comb begin
        ins_kind = INS_NONE;
        tgt_way  = '0;
        if (ins_acc) begin
            if (do_extract) begin
                ins_kind = INS_SWAP;
                tgt_way  = hit_way;
            end else if (|ins_vec) begin
                ins_kind = INS_MERGE;
                tgt_way  = merge_way;
            end else if (!(&valid_q)) begin
                ins_kind = INS_FILL;
                tgt_way  = free_way;
            end else begin
                ins_kind = INS_REPLACE;
                tgt_way  = lru_way;
            end
        end
    end

    // An accepted insert owns the recency update; otherwise a probe touches or extracts.
    always_comb begin
        touch_en  = (ins_kind != INS_NONE) || (probe_hit && !do_extract);
        touch_way = (ins_kind != INS_NONE) ? tgt_way : hit_way;
        inval_en  = (ins_kind == INS_NONE) && do_extract;
    end

    assign new_evict = (ins_kind == INS_REPLACE) && valid_q[tgt_way] && dirty_q[tgt_way];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        data_d  = data_q;
        occ_d   = occ_q;
        if (ins_kind != INS_NONE) begin
            valid_d[tgt_way] = 1'b1;
            tag_d[tgt_way]   = bus.insert_tag;
            idx_d[tgt_way]   = bus.insert_idx;
            data_d[tgt_way]  = bus.insert_data;
            dirty_d[tgt_way] = (ins_kind == INS_MERGE) ? (dirty_q[tgt_way] | bus.insert_dirty)
                                                       : bus.insert_dirty;
            if (ins_kind == INS_FILL)
                occ_d = occ_q + 1'b1;
        end else if (do_extract) begin
            valid_d[hit_way] = 1'b0;
            dirty_d[hit_way] = 1'b0;
            occ_d            = occ_q - 1'b1;
        end
    end

    // A drain and a fresh dirty eviction on the same edge keep evict_val high.
    always_comb begin
        evict_val_d  = evict_val_q;
        evict_tag_d  = evict_tag_q;
        evict_idx_d  = evict_idx_q;
        evict_data_d = evict_data_q;
        if (new_evict) begin
            evict_val_d  = 1'b1;
            evict_tag_d  = tag_q[tgt_way];
            evict_idx_d  = idx_q[tgt_way];
            evict_data_d = data_q[tgt_way];
        end else if (bus.evict_rdy) begin
            evict_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            occ_q       <= '0;
            evict_val_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            occ_q       <= occ_d;
            evict_val_q <= evict_val_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q        <= tag_d;
        idx_q        <= idx_d;
        data_q       <= data_d;
        evict_tag_q  <= evict_tag_d;
        evict_idx_q  <= evict_idx_d;
        evict_data_q <= evict_data_d;
    end

    assign bus.lookup_hit   = hit_any;
    assign bus.lookup_way   = hit_any ? hit_way : '0;
    assign bus.lookup_data  = hit_any ? data_q[hit_way] : '0;
    assign bus.lookup_dirty = hit_any ? dirty_q[hit_way] : 1'b0;
    assign bus.insert_rdy   = insert_rdy;
    assign bus.evict_val    = evict_val_q;
    assign bus.evict_tag    = evict_tag_q;
    assign bus.evict_idx    = evict_idx_q;
    assign bus.evict_data   = evict_data_q;
    assign bus.occupancy    = occ_q;

endmodule

// File: tb/tb_riscv_victim_cache_assoc.sv
// Bench for the victim cache: directed scenarios plus randomized traffic
// compared against a recency-list reference model.
module tb_riscv_victim_cache_assoc;
    import riscv_victim_cache_assoc_pkg::*;

    localparam int N  = VC_ENTRIES;
    localparam int WW = VC_WAY_W;
    localparam int TW = VC_TAG_W;
    localparam int IW = VC_IDX_W;
    localparam int BW = VC_BLK_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    riscv_victim_cache_assoc_if #(.WAY_W(WW), .TAG_W(TW), .IDX_W(IW), .BLK_W(BW)) bus ();

    riscv_victim_cache_assoc #(
        .ENTRIES (N), .WAY_W (WW), .TAG_W (TW), .IDX_W (IW), .BLK_W (BW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents per way plus a recency list (front = MRU).
    bit            m_valid [N];
    bit            m_dirty [N];
    logic [TW-1:0] m_tag   [N];
    logic [IW-1:0] m_idx   [N];
    logic [BW-1:0] m_data  [N];
    int            order[$];
    int            m_occ;
    bit            m_ev_val;
    logic [TW-1:0] m_ev_tag;
    logic [IW-1:0] m_ev_idx;
    logic [BW-1:0] m_ev_data;

    function automatic int m_find(logic [TW-1:0] t, logic [IW-1:0] x);
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == t && m_idx[i] == x) return i;
        return -1;
    endfunction

    task automatic m_move(int w, bit to_front);
        for (int k = 0; k < order.size(); k++) begin
            if (order[k] == w) begin
                order.delete(k);
                break;
            end
        end
        if (to_front) order.push_front(w);
        else          order.push_back(w);
    endtask

    task automatic m_reset();
        order.delete();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            order.push_back(i);
        end
        m_occ    = 0;
        m_ev_val = 0;
    endtask

    task automatic model_clock();
        int  h, f, w;
        bit  probe, acc, new_ev;
        logic [TW-1:0] vt;
        logic [IW-1:0] vi;
        logic [BW-1:0] vd;
        vt = '0; vi = '0; vd = '0;
        h      = m_find(bus.lookup_tag, bus.lookup_idx);
        probe  = bus.lookup_en && (h >= 0);
        acc    = bus.insert_en && (!m_ev_val || bus.evict_rdy);
        new_ev = 0;
        if (acc) begin
            f = m_find(bus.insert_tag, bus.insert_idx);
            if (bus.extract_en && probe) begin
                w = h;
                m_dirty[w] = bus.insert_dirty;
            end else if (f >= 0) begin
                w = f;
                m_dirty[w] = m_dirty[w] | bus.insert_dirty;
            end else begin
                w = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) w = i;
                if (w >= 0) begin
                    m_occ++;
                end else begin
                    w = order[N-1];
                    if (m_dirty[w]) begin
                        new_ev = 1;
                        vt = m_tag[w]; vi = m_idx[w]; vd = m_data[w];
                    end
                end
                m_dirty[w] = bus.insert_dirty;
            end
            m_valid[w] = 1;
            m_tag[w]   = bus.insert_tag;
            m_idx[w]   = bus.insert_idx;
            m_data[w]  = bus.insert_data;
            m_move(w, 1);
        end else if (bus.extract_en && probe) begin
            m_valid[h] = 0;
            m_dirty[h] = 0;
            m_occ--;
            m_move(h, 0);
        end else if (probe) begin
            m_move(h, 1);
        end
        if (new_ev) begin
            m_ev_val = 1; m_ev_tag = vt; m_ev_idx = vi; m_ev_data = vd;
        end else if (bus.evict_rdy) begin
            m_ev_val = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) m_reset();
        else       model_clock();
        #1;
    endtask

    task automatic idle();
        bus.lookup_en    = 0; bus.lookup_tag  = '0; bus.lookup_idx = '0;
        bus.extract_en   = 0; bus.insert_en   = 0;
        bus.insert_tag   = '0; bus.insert_idx = '0; bus.insert_data = '0;
        bus.insert_dirty = 0;
    endtask

    task automatic peek(logic [TW-1:0] t, logic [IW-1:0] x);
        bus.lookup_en  = 0;
        bus.lookup_tag = t;
        bus.lookup_idx = x;
        #1;
    endtask

    task automatic do_insert(logic [TW-1:0] t, logic [IW-1:0] x, logic [BW-1:0] d, bit dty);
        bus.insert_en = 1; bus.insert_tag = t; bus.insert_idx = x;
        bus.insert_data = d; bus.insert_dirty = dty;
        tick();
        bus.insert_en = 0;
    endtask

    task automatic touch(logic [TW-1:0] t);
        bus.lookup_en = 1; bus.lookup_tag = t; bus.lookup_idx = '0;
        tick();
        bus.lookup_en = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        bus.evict_rdy = 1;
        do_reset();
        checks++; if (bus.occupancy !== '0) begin errors++; $display("[TB] FAIL reset_occ: got %0d expected 0", bus.occupancy); end
        checks++; if (bus.evict_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_evict_val: got %0b expected 0", bus.evict_val); end
        checks++; if (bus.insert_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_insert_rdy: got %0b expected 1", bus.insert_rdy); end
        peek(1, 0);
        checks++; if (bus.lookup_hit !== 1'b0 || bus.lookup_way !== '0 || bus.lookup_data !== '0)
            begin errors++; $display("[TB] FAIL reset_lookup: hit %0b way %0d data %0h expected 0 0 0", bus.lookup_hit, bus.lookup_way, bus.lookup_data); end
    endtask

    task automatic test_fill();
        for (int t = 1; t <= 4; t++) do_insert(TW'(t), 0, BW'(32'h1000 + t), 0);
        checks++; if (bus.occupancy !== 3'd4) begin errors++; $display("[TB] FAIL fill_occ: got %0d expected 4", bus.occupancy); end
        checks++; if (bus.evict_val !== 1'b0) begin errors++; $display("[TB] FAIL fill_evict_val: got %0b expected 0", bus.evict_val); end
        peek(3, 0);
        checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_way !== 2'd2 || bus.lookup_data !== BW'(32'h1003))
            begin errors++; $display("[TB] FAIL fill_lookup3: hit %0b way %0d data %0h expected 1 2 1003", bus.lookup_hit, bus.lookup_way, bus.lookup_data); end
    endtask

    task automatic test_clean_replace();
        touch(1);
        do_insert(5, 0, BW'(32'h1005), 0);
        checks++; if (bus.evict_val !== 1'b0) begin errors++; $display("[TB] FAIL clean_replace_evict: got %0b expected 0", bus.evict_val); end
        peek(2, 0);
        checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("[TB] FAIL clean_replace_tag2: hit %0b expected 0", bus.lookup_hit); end
        peek(5, 0);
        checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_way !== 2'd1)
            begin errors++; $display("[TB] FAIL clean_replace_tag5: hit %0b way %0d expected 1 1", bus.lookup_hit, bus.lookup_way); end
        checks++; if (bus.occupancy !== 3'd4) begin errors++; $display("[TB] FAIL clean_replace_occ: got %0d expected 4", bus.occupancy); end
    endtask

    task automatic test_swap();
        bus.lookup_en = 1; bus.lookup_tag = 3; bus.lookup_idx = 0; bus.extract_en = 1;
        bus.insert_en = 1; bus.insert_tag = 7; bus.insert_idx = 0;
        bus.insert_data = BW'(32'h1007); bus.insert_dirty = 0;
        #1;
        checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_way !== 2'd2)
            begin errors++; $display("[TB] FAIL swap_probe: hit %0b way %0d expected 1 2", bus.lookup_hit, bus.lookup_way); end
        tick();
        idle();
        peek(7, 0);
        checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_way !== 2'd2 || bus.lookup_data !== BW'(32'h1007))
            begin errors++; $display("[TB] FAIL swap_tag7: hit %0b way %0d data %0h expected 1 2 1007", bus.lookup_hit, bus.lookup_way, bus.lookup_data); end
        peek(3, 0);
        checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("[TB] FAIL swap_tag3_gone: hit %0b expected 0", bus.lookup_hit); end
        checks++; if (bus.occupancy !== 3'd4 || bus.evict_val !== 1'b0)
            begin errors++; $display("[TB] FAIL swap_occ_evict: occ %0d evict %0b expected 4 0", bus.occupancy, bus.evict_val); end
    endtask

    task automatic test_merge();
        do_insert(7, 0, BW'(32'hA5A5A5A5), 1);
        peek(7, 0);
        checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_way !== 2'd2 || bus.lookup_dirty !== 1'b1)
            begin errors++; $display("[TB] FAIL merge_tag7: hit %0b way %0d dirty %0b expected 1 2 1", bus.lookup_hit, bus.lookup_way, bus.lookup_dirty); end
        checks++; if (bus.lookup_data !== BW'(32'hA5A5A5A5)) begin errors++; $display("[TB] FAIL merge_data: got %0h expected a5a5a5a5", bus.lookup_data); end
        checks++; if (bus.occupancy !== 3'd4) begin errors++; $display("[TB] FAIL merge_occ: got %0d expected 4", bus.occupancy); end
        peek(1, 0);
        checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_way !== 2'd0)
            begin errors++; $display("[TB] FAIL merge_tag1_kept: hit %0b way %0d expected 1 0", bus.lookup_hit, bus.lookup_way); end
    endtask

    task automatic test_dirty_evict();
        touch(4); touch(1); touch(5);
        bus.evict_rdy = 0;
        do_insert(9, 0, BW'(32'h1009), 0);
        checks++; if (bus.evict_val !== 1'b1) begin errors++; $display("[TB] FAIL evict_val_set: got %0b expected 1", bus.evict_val); end
        checks++; if (bus.evict_tag !== TW'(7) || bus.evict_idx !== '0 || bus.evict_data !== BW'(32'hA5A5A5A5))
            begin errors++; $display("[TB] FAIL evict_contents: tag %0h idx %0h data %0h expected 7 0 a5a5a5a5", bus.evict_tag, bus.evict_idx, bus.evict_data); end
        peek(9, 0);
        checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_way !== 2'd2)
            begin errors++; $display("[TB] FAIL evict_tag9: hit %0b way %0d expected 1 2", bus.lookup_hit, bus.lookup_way); end
        for (int c = 0; c < 3; c++) begin
            bus.insert_en = 1; bus.insert_tag = 11; bus.insert_idx = 0; bus.insert_dirty = 1;
            #1;
            checks++; if (bus.insert_rdy !== 1'b0) begin errors++; $display("[TB] FAIL stall_insert_rdy: got %0b expected 0", bus.insert_rdy); end
            tick();
            bus.insert_en = 0;
            checks++; if (bus.evict_val !== 1'b1 || bus.evict_tag !== TW'(7) || bus.evict_data !== BW'(32'hA5A5A5A5))
                begin errors++; $display("[TB] FAIL stall_stable: val %0b tag %0h data %0h expected 1 7 a5a5a5a5", bus.evict_val, bus.evict_tag, bus.evict_data); end
        end
        peek(11, 0);
        checks++; if (bus.lookup_hit !== 1'b0 || bus.occupancy !== 3'd4)
            begin errors++; $display("[TB] FAIL stall_no_change: hit %0b occ %0d expected 0 4", bus.lookup_hit, bus.occupancy); end
        bus.evict_rdy = 1;
        tick();
        checks++; if (bus.evict_val !== 1'b0 || bus.insert_rdy !== 1'b1)
            begin errors++; $display("[TB] FAIL drain: val %0b rdy %0b expected 0 1", bus.evict_val, bus.insert_rdy); end
    endtask

    task automatic test_reset_mid_evict();
        do_reset();
        for (int t = 10; t <= 13; t++) do_insert(TW'(t), 0, BW'(32'h2000 + t), 1);
        bus.evict_rdy = 0;
        do_insert(14, 0, BW'(32'h200E), 0);
        checks++; if (bus.evict_val !== 1'b1 || bus.evict_tag !== TW'(10))
            begin errors++; $display("[TB] FAIL pre_reset_evict: val %0b tag %0h expected 1 a", bus.evict_val, bus.evict_tag); end
        reset = 1;
        tick();
        reset = 0;
        checks++; if (bus.evict_val !== 1'b0 || bus.occupancy !== '0)
            begin errors++; $display("[TB] FAIL mid_evict_reset: val %0b occ %0d expected 0 0", bus.evict_val, bus.occupancy); end
        for (int t = 10; t <= 14; t++) begin
            peek(TW'(t), 0);
            checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("[TB] FAIL mid_evict_reset_lookup: tag %0d hit %0b expected 0", t, bus.lookup_hit); end
        end
        bus.evict_rdy = 1;
    endtask

    task automatic test_random();
        int h;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.lookup_en    = ($urandom_range(0, 9) < 7);
            bus.lookup_tag   = TW'($urandom_range(1, 6));
            bus.lookup_idx   = IW'($urandom_range(0, 1));
            bus.extract_en   = ($urandom_range(0, 9) < 3);
            bus.insert_en    = ($urandom_range(0, 1) == 1);
            bus.insert_tag   = TW'($urandom_range(1, 6));
            bus.insert_idx   = IW'($urandom_range(0, 1));
            bus.insert_data  = BW'($urandom);
            bus.insert_dirty = ($urandom_range(0, 1) == 1);
            bus.evict_rdy    = ($urandom_range(0, 9) < 6);
            #2;
            h = m_find(bus.lookup_tag, bus.lookup_idx);
            checks++;
            if (bus.lookup_hit !== (h >= 0) ||
                bus.lookup_way !== ((h >= 0) ? WW'(h) : '0) ||
                bus.lookup_data !== ((h >= 0) ? m_data[h] : '0) ||
                bus.lookup_dirty !== ((h >= 0) ? m_dirty[h] : 1'b0)) begin
                errors++;
                $display("[TB] FAIL rand_lookup cyc %0d: hit %0b way %0d data %0h dirty %0b expected way %0d",
                         c, bus.lookup_hit, bus.lookup_way, bus.lookup_data, bus.lookup_dirty, h);
            end
            checks++;
            if (bus.insert_rdy !== (!m_ev_val || bus.evict_rdy) || bus.evict_val !== m_ev_val ||
                bus.occupancy !== (WW+1)'(m_occ)) begin
                errors++;
                $display("[TB] FAIL rand_status cyc %0d: rdy %0b val %0b occ %0d expected val %0b occ %0d",
                         c, bus.insert_rdy, bus.evict_val, bus.occupancy, m_ev_val, m_occ);
            end
            if (m_ev_val) begin
                checks++;
                if (bus.evict_tag !== m_ev_tag || bus.evict_idx !== m_ev_idx || bus.evict_data !== m_ev_data) begin
                    errors++;
                    $display("[TB] FAIL rand_evict cyc %0d: tag %0h idx %0h data %0h expected %0h %0h %0h",
                             c, bus.evict_tag, bus.evict_idx, bus.evict_data, m_ev_tag, m_ev_idx, m_ev_data);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 0;
        idle();
        bus.evict_rdy = 1;
        m_reset();
        test_reset();
        test_fill();
        test_clean_replace();
        test_swap();
        test_merge();
        test_dirty_evict();
        test_reset_mid_evict();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
